// File: rtl/serial_adder_ctrl_if.sv
// Request/response bundle between a client and serial_adder_ctrl.
// The client (master) drives start, the operands and the initial carry.
// The controller (slave) returns busy, done, result and cout.
// When SERIAL_ADDER_OVF_EN is defined, the bundle also carries the
// signed-overflow flag ovf.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin_init;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (
        output start, op_a, op_b, cin_init,
        input  busy, done, result, cout, ovf
    );

    modport slave (
        input  start, op_a, op_b, cin_init,
        output busy, done, result, cout, ovf
    );
`else
    modport master (
        output start, op_a, op_b, cin_init,
        input  busy, done, result, cout
    );

    modport slave (
        input  start, op_a, op_b, cin_init,
        output busy, done, result, cout
    );
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add controller for an external single-bit Full_Adder.
// The block captures two WIDTH-bit operands and feeds them to the adder
// LSB-first, one bit per clock, on fa_a/fa_b/fa_cin. It keeps the ripple
// carry in a flop, gathers the returned sum bits and, after WIDTH bit
// cycles, presents {cout, result} with a one-cycle done pulse.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the ovf output, the
// two's-complement overflow of the last addition.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_adder_ctrl_if.slave bus,
    output logic               fa_a,
    output logic               fa_b,
    output logic               fa_cin,
    input  logic               fa_sum,
    input  logic               fa_carry
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Only the WIDTH-1 sum bits that arrive before the final one are
    // kept here; the final bit goes straight into result.
    logic [WIDTH-2:0] sum_sh;
    logic [WIDTH-1:0] sum_next;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;
    logic             last_bit;

    logic [WIDTH-1:0] result_q;
    logic             cout_q;

    // Sum register after absorbing this cycle's fa_sum at the MSB.
    assign sum_next = {fa_sum, sum_sh};
    assign last_bit = (state_q == RUN) && (cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: a start is honoured only in IDLE, RUN lasts WIDTH
    // cycles and DONE lasts exactly one.
    always_comb begin
        // NOTE: the default assignment first means no path leaves state_d
        // unassigned, so no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_bit)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, bit-serial shifting, carry tracking and result latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            sum_sh   <= '0;
            carry_q  <= 1'b0;
            cnt      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_sh    <= bus.op_a;
                        b_sh    <= bus.op_b;
                        carry_q <= bus.cin_init;
                        cnt     <= '0;
                        sum_sh  <= '0;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    sum_sh  <= sum_next[WIDTH-1:1];
                    carry_q <= fa_carry;
                    if (cnt == CNT_LAST) begin
                        // The final sum bit and carry-out come back this
                        // cycle, so they are taken from the adder directly.
                        result_q <= sum_next;
                        cout_q   <= fa_carry;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;

    // Signed overflow: carry into the MSB differs from the carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (last_bit) begin
            ovf_q <= carry_q ^ fa_carry;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    // Status and adder drive are plain decodes of registered state; the
    // adder inputs are held at 0 whenever no bit is being processed.
    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
    assign bus.cout   = cout_q;

    assign fa_a   = (state_q == RUN) && a_sh[0];
    assign fa_b   = (state_q == RUN) && b_sh[0];
    assign fa_cin = (state_q == RUN) && carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl with a behavioural Full_Adder.
// Stimulus pushes the arithmetic expectation into a queue; an independent
// monitor pops and compares whenever done is seen.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] result;
        logic             cout;
        logic             ovf;
        string            name;
    } exp_t;

    logic clk;
    logic rst_n;
    logic fa_a;
    logic fa_b;
    logic fa_cin;
    logic fa_sum;
    logic fa_carry;

    serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .fa_a     (fa_a),
        .fa_b     (fa_b),
        .fa_cin   (fa_cin),
        .fa_sum   (fa_sum),
        .fa_carry (fa_carry)
    );

    // The external single-bit full adder.
    assign fa_sum   = fa_a ^ fa_b ^ fa_cin;
    assign fa_carry = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_done = 0;
    int   n_push = 0;
    exp_t exp_q[$];

    logic [WIDTH-1:0] prev_res  = '0;
    logic             prev_cout = 1'b0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference: plain unsigned addition; overflow from operand/result signs.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic c, input string name);
        exp_t        e;
        logic [WIDTH:0] full;
        full     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
        e.result = full[WIDTH-1:0];
        e.cout   = full[WIDTH];
        e.ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        e.name   = name;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'(bus.done), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, ".result"}, 64'(bus.result), 64'(e.result));
                    check({e.name, ".cout"}, 64'(bus.cout), 64'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
                    check({e.name, ".ovf"}, 64'(bus.ovf), 64'(e.ovf));
`endif
                end
            end
        end
    end

    // One addition with latency, busy and hold checks. inject_at > 0 pulses
    // a start with all-ones operands at that RUN cycle; it must be ignored.
    task automatic do_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input string name, input int inject_at);
        exp_t e;
        int   lat;
        int   gaps;
        e = model(a, b, c, name);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.cin_init = c;
        @(posedge clk);
        exp_q.push_back(e);
        n_push++;
        lat  = 0;
        gaps = 0;
        for (int i = 1; i <= WIDTH + 4 && lat == 0; i++) begin
            @(negedge clk);
            if (i == inject_at) begin
                bus.start    = 1'b1;
                bus.op_a     = '1;
                bus.op_b     = '1;
                bus.cin_init = 1'b1;
            end else begin
                bus.start    = 1'b0;
                bus.op_a     = WIDTH'($urandom);
                bus.op_b     = WIDTH'($urandom);
                bus.cin_init = 1'($urandom);
            end
            if (!bus.busy) gaps++;
            if (i == 2) begin
                check({name, ".hold_result"}, 64'(bus.result), 64'(prev_res));
                check({name, ".hold_cout"}, 64'(bus.cout), 64'(prev_cout));
            end
            if (bus.done) lat = i;
        end
        bus.start = 1'b0;
        check({name, ".latency"}, 64'(lat), 64'(WIDTH + 1));
        check({name, ".busy_gaps"}, 64'(gaps), 64'd0);
        @(negedge clk);
        check({name, ".idle_after"}, {62'd0, bus.busy, bus.done}, 64'd0);
        check({name, ".held"}, 64'({bus.cout, bus.result}), 64'({e.cout, e.result}));
        prev_res  = e.result;
        prev_cout = e.cout;
    endtask

    // Start an addition, then reset at RUN cycle abort_at.
    task automatic abort_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int abort_at);
        int dones;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.cin_init = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 2; i <= abort_at; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort.busy", 64'(bus.busy), 64'd0);
        check("abort.done", 64'(bus.done), 64'd0);
        check("abort.result", 64'({bus.cout, bus.result}), 64'd0);
        check("abort.fa", {61'd0, fa_a, fa_b, fa_cin}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (WIDTH + 4) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("abort.no_done", 64'(dones), 64'd0);
        prev_res  = '0;
        prev_cout = 1'b0;
    endtask

    initial begin
        int idle_dones;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.op_a     = '0;
        bus.op_b     = '0;
        bus.cin_init = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.status", {62'd0, bus.busy, bus.done}, 64'd0);
        check("reset.result", 64'({bus.cout, bus.result}), 64'd0);
        check("reset.fa", {61'd0, fa_a, fa_b, fa_cin}, 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("reset.ovf", 64'(bus.ovf), 64'd0);
`endif
        rst_n = 1'b1;
        idle_dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done || bus.busy) idle_dones++;
        end
        check("idle.activity", 64'(idle_dones), 64'd0);
        check("idle.fa", {61'd0, fa_a, fa_b, fa_cin}, 64'd0);

        do_add(WIDTH'(8'h00), WIDTH'(8'h00), 1'b0, "zero", 0);
        do_add(WIDTH'(8'hFF), WIDTH'(8'h01), 1'b0, "ff_plus_1", 0);
        do_add(WIDTH'(8'h5A), WIDTH'(8'hA5), 1'b1, "5a_a5_c1", 0);
        do_add(WIDTH'(8'h12), WIDTH'(8'h34), 1'b0, "ignored_start", 3);
        abort_add(WIDTH'(8'h77), WIDTH'(8'h11), 4);
        do_add(WIDTH'(8'h0F), WIDTH'(8'h01), 1'b0, "after_abort", 0);
        do_add(WIDTH'(8'hFF), WIDTH'(8'hFF), 1'b1, "all_ones", 0);
        do_add(WIDTH'(8'h7F), WIDTH'(8'h01), 1'b0, "pos_ovf", 0);
        do_add(WIDTH'(8'h80), WIDTH'(8'h80), 1'b0, "neg_ovf", 0);

        for (int k = 0; k < 40; k++) begin
            do_add(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), $sformatf("rand%0d", k), 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check("end.queue_empty", 64'(exp_q.size()), 64'd0);
        check("end.done_count", 64'(n_done), 64'(n_push));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
